fwd_scoreboard: RTL and testbench
=================================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter AW, default 5: register address width.
REQ-002 Parameter DEPTH, default 3: tracked slots after ID/EX (1=EX/MEM, 2=MEM/WB, 3=post-WB).
REQ-003 Parameter LOAD_LAT, default 2: first slot at which load data is forwardable; range 1..DEPTH.
REQ-004 Derived SELW = clog2(DEPTH+1); select 0 means register file, k means slot k.
REQ-005 clk_i  in  1  sole clock, rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 id_valid_i  in  1  ID stage holds a real instruction.
REQ-008 id_rs1_i, id_rs2_i  in  AW  ID source addresses.
REQ-009 id_rs1_used_i, id_rs2_used_i  in  1  source actually read.
REQ-010 id_rd_i  in  AW  ID destination address.
REQ-011 id_regwrite_i, id_memread_i  in  1  ID writes rd / is a load.
REQ-012 flush_i  in  1  squash the instructions in ID and ID/EX.
REQ-013 stall_o  out  1  hold PC and IF/ID, insert bubble into ID/EX (combinational).
REQ-014 fwd1_sel_o, fwd2_sel_o  out  SELW  registered operand-source selects for the EX-stage instruction.

Function
REQ-015 Slot record = {valid, rd, regwrite, memread}; slot0 = ID/EX, slots 1..DEPTH as in REQ-002.
REQ-016 Every cycle, slot[k] <= slot[k-1] for k = 1..DEPTH; slot DEPTH contents are discarded.
REQ-017 Advance = id_valid_i & !stall_o & !flush_i; on advance, slot0 <= ID fields, otherwise slot0 <= invalid bubble.
REQ-018 Producer match for a source: slot j (0..DEPTH-1) valid, regwrite, rd != 0, rd == rs, rs_used; the youngest (lowest j) match wins.
REQ-019 On advance, fwdN_sel_o <= j+1 for the winning match, else 0; when not advancing, fwdN_sel_o <= 0.
REQ-020 stall_o = id_valid_i & !flush_i & (either winning match is a load with j+1 < LOAD_LAT).
REQ-021 An older matching load never causes a stall when a younger non-load match shadows it.
REQ-022 rs == 0 never matches, forwards, or stalls.
REQ-023 rs1 and rs2 are resolved independently; stall if either source requires it.
REQ-024 flush_i overrides stall: stall_o = 0, slot0 becomes a bubble, and selects go to 0 next cycle; slots 1..DEPTH are unaffected.
REQ-025 A stall persists until the load reaches slot LOAD_LAT-1; the default parameters give exactly 1 stall cycle.

Reset
REQ-026 With rst_i high at a clock edge, all slots become invalid and fwd1_sel_o = fwd2_sel_o = 0.
REQ-027 stall_o = 0 while all slots are invalid; reset mid-stall releases the stall on the following cycle.

Configuration
REQ-028 Macro FWD_WB_BYPASS_EN defined: matches are searched in slots 0..DEPTH-1 (the post-WB slot is reachable, select value DEPTH).
REQ-029 Macro absent: the search covers slots 0..DEPTH-2 only, the maximum select is DEPTH-1, and the register file provides write-through.

Structure
REQ-030 Package fwd_pkg SHALL hold the slot record typedef, SEL_RF = 0, and the default parameter constants.
REQ-031 Sub-module fwd_match SHALL hold the youngest-match priority search for one source, instantiated twice.

Verification
REQ-032 ALU op x5 in slot0, consumer reads x5 with advance -> next cycle fwd1_sel_o = 1, stall_o = 0.
REQ-033 Load x7 in slot0, consumer rs2 = x7 -> stall_o = 1 for 1 cycle, then fwd2_sel_o = 2 after the advance.
REQ-034 Load x7 in slot1, ALU op writing x7 in slot0, consumer reads x7 -> no stall, fwd1_sel_o = 1.
REQ-035 Producer rd = x0 with regwrite, consumer reads x0 -> stall_o = 0, selects 0.
REQ-036 Stall condition present and flush_i = 1 in the same cycle -> stall_o = 0, next cycle selects = 0 and slot0 is a bubble.
REQ-037 Match only in slot2 -> with FWD_WB_BYPASS_EN, sel = 3; without it, sel = 0.

Source files
------------

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared definitions for the forwarding scoreboard.
//   slot_t       - per-slot producer record {valid, rd, regwrite, memread}
//   SEL_RF       - operand select value meaning "read the register file"
//   *_DEFAULT    - default parameter values for fwd_scoreboard
//   AW_MAX       - storage width of rd inside slot_t (AW must not exceed it)
//   is_producer  - slot holds a valid instruction that writes a non-zero rd
package fwd_pkg;

  localparam int unsigned AW_DEFAULT       = 5;
  localparam int unsigned DEPTH_DEFAULT    = 3;
  localparam int unsigned LOAD_LAT_DEFAULT = 2;
  localparam int unsigned AW_MAX           = 16;
  localparam int unsigned SEL_RF           = 0;

  // rd is held at AW_MAX bits so the record can live in a non-parameterized
  // package; narrower addresses are zero-extended on entry.
  typedef struct packed {
    logic              valid;
    logic [AW_MAX-1:0] rd;
    logic              regwrite;
    logic              memread;
  } slot_t;

  function automatic logic is_producer(slot_t s);
    return s.valid & s.regwrite & (s.rd != '0);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// fwd_match: youngest-producer priority search for one source operand.
// Ports:
//   slots_i  in   NSLOT slot records, index 0 is the youngest (ID/EX)
//   rs_i     in   source register address (zero-extended to AW_MAX)
//   used_i   in   source is actually read
//   hit_o    out  some searched slot produces rs_i
//   sel_o    out  winning slot index + 1, SEL_RF when no hit
//   load_o   out  winning producer is a load
module fwd_match
  import fwd_pkg::*;
#(
  parameter int unsigned NSLOT = 2,
  parameter int unsigned SELW  = 2
) (
  input  slot_t             slots_i [NSLOT],
  input  logic [AW_MAX-1:0] rs_i,
  input  logic              used_i,
  output logic              hit_o,
  output logic [SELW-1:0]   sel_o,
  output logic              load_o
);

  // First hit in ascending order wins, so an older load is shadowed by any
  // younger producer of the same register.
  always_comb begin
    hit_o  = 1'b0;
    sel_o  = SELW'(SEL_RF);
    load_o = 1'b0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (!hit_o && used_i && is_producer(slots_i[i]) && (slots_i[i].rd == rs_i)) begin
        hit_o  = 1'b1;
        sel_o  = SELW'(i + 1);
        load_o = slots_i[i].memread;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: tracks producers behind ID, generates load-use stalls and
// registered EX-stage operand forwarding selects.
// Config macro: FWD_WB_BYPASS_EN - when defined, the post-WB slot is also
//   searched (max select DEPTH); otherwise the register file is assumed to
//   write through and the search stops one slot earlier (needs DEPTH >= 2).
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   id_valid_i                      ID holds a real instruction
//   id_rs1_i/id_rs2_i               ID source addresses
//   id_rs1_used_i/id_rs2_used_i     source actually read
//   id_rd_i, id_regwrite_i          ID destination and write enable
//   id_memread_i                    ID instruction is a load
//   flush_i                         squash ID and ID/EX
//   stall_o                         combinational load-use stall
//   fwd1_sel_o/fwd2_sel_o           registered selects, 0 = register file
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter  int unsigned AW       = AW_DEFAULT,
  parameter  int unsigned DEPTH    = DEPTH_DEFAULT,
  parameter  int unsigned LOAD_LAT = LOAD_LAT_DEFAULT,
  localparam int unsigned SELW     = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            id_valid_i,
  input  logic [AW-1:0]   id_rs1_i,
  input  logic [AW-1:0]   id_rs2_i,
  input  logic            id_rs1_used_i,
  input  logic            id_rs2_used_i,
  input  logic [AW-1:0]   id_rd_i,
  input  logic            id_regwrite_i,
  input  logic            id_memread_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [SELW-1:0] fwd1_sel_o,
  output logic [SELW-1:0] fwd2_sel_o
);

`ifdef FWD_WB_BYPASS_EN
  localparam int unsigned NSRCH = DEPTH;
`else
  localparam int unsigned NSRCH = DEPTH - 1;
`endif

  localparam logic [SELW-1:0] LAT_SEL = SELW'(LOAD_LAT);

  // Only the searched slots are stored: anything shifted past them can never
  // be matched again, so dropping it early is observably identical.
  slot_t           slot_q [NSRCH];
  slot_t           slot0_d;
  logic [SELW-1:0] fwd1_sel_q, fwd1_sel_d;
  logic [SELW-1:0] fwd2_sel_q, fwd2_sel_d;

  logic            hit1, hit2, load1, load2;
  logic [SELW-1:0] sel1, sel2;
  logic            advance;

  fwd_match #(.NSLOT(NSRCH), .SELW(SELW)) u_match_rs1 (
    .slots_i (slot_q),
    .rs_i    (AW_MAX'(id_rs1_i)),
    .used_i  (id_rs1_used_i),
    .hit_o   (hit1),
    .sel_o   (sel1),
    .load_o  (load1)
  );

  fwd_match #(.NSLOT(NSRCH), .SELW(SELW)) u_match_rs2 (
    .slots_i (slot_q),
    .rs_i    (AW_MAX'(id_rs2_i)),
    .used_i  (id_rs2_used_i),
    .hit_o   (hit2),
    .sel_o   (sel2),
    .load_o  (load2)
  );

  // A load is not yet forwardable while its select would be below LOAD_LAT.
  assign stall_o = id_valid_i & ~flush_i &
                   ((hit1 & load1 & (sel1 < LAT_SEL)) |
                    (hit2 & load2 & (sel2 < LAT_SEL)));

  assign advance = id_valid_i & ~stall_o & ~flush_i;

  always_comb begin
    slot0_d    = '0;
    fwd1_sel_d = SELW'(SEL_RF);
    fwd2_sel_d = SELW'(SEL_RF);
    if (advance) begin
      slot0_d.valid    = 1'b1;
      slot0_d.rd       = AW_MAX'(id_rd_i);
      slot0_d.regwrite = id_regwrite_i;
      slot0_d.memread  = id_memread_i;
      fwd1_sel_d       = sel1;
      fwd2_sel_d       = sel2;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NSRCH; i++) begin
        slot_q[i] <= '0;
      end
      fwd1_sel_q <= '0;
      fwd2_sel_q <= '0;
    end else begin
      slot_q[0] <= slot0_d;
      for (int unsigned i = 1; i < NSRCH; i++) begin
        slot_q[i] <= slot_q[i-1];
      end
      fwd1_sel_q <= fwd1_sel_d;
      fwd2_sel_q <= fwd2_sel_d;
    end
  end

  assign fwd1_sel_o = fwd1_sel_q;
  assign fwd2_sel_o = fwd2_sel_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed scenarios plus randomized traffic against a
// queue-based reference model of the forwarding/stall rules.
module tb_fwd_scoreboard;

  localparam int unsigned AW       = 5;
  localparam int unsigned DEPTH    = 3;
  localparam int unsigned LOAD_LAT = 2;
  localparam int unsigned SELW     = $clog2(DEPTH + 1);
`ifdef FWD_WB_BYPASS_EN
  localparam int unsigned NS      = DEPTH;
  localparam int unsigned WB_SEL  = 3;
`else
  localparam int unsigned NS      = DEPTH - 1;
  localparam int unsigned WB_SEL  = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_i;
  logic            id_valid_i;
  logic [AW-1:0]   id_rs1_i, id_rs2_i, id_rd_i;
  logic            id_rs1_used_i, id_rs2_used_i;
  logic            id_regwrite_i, id_memread_i;
  logic            flush_i;
  logic            stall_o;
  logic [SELW-1:0] fwd1_sel_o, fwd2_sel_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_scoreboard #(.AW(AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .id_rd_i       (id_rd_i),
    .id_regwrite_i (id_regwrite_i),
    .id_memread_i  (id_memread_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .fwd1_sel_o    (fwd1_sel_o),
    .fwd2_sel_o    (fwd2_sel_o)
  );

  // Reference model: history of what entered ID/EX, youngest at index 0.
  typedef struct {
    bit          v;
    int unsigned rd;
    bit          rw;
    bit          ld;
  } ins_t;

  ins_t        hist[$];
  int unsigned exp_sel1 = 0;
  int unsigned exp_sel2 = 0;

  function automatic void search(input int unsigned rs, input bit used,
                                 output int unsigned sel, output bit ld);
    sel = 0;
    ld  = 1'b0;
    if (!used || rs == 0) return;
    for (int unsigned d = 0; d < NS; d++) begin
      if (hist[d].v && hist[d].rw && hist[d].rd == rs) begin
        sel = d + 1;
        ld  = hist[d].ld;
        return;
      end
    end
  endfunction

  function automatic bit model_stall();
    int unsigned s1, s2;
    bit l1, l2;
    search(id_rs1_i, id_rs1_used_i, s1, l1);
    search(id_rs2_i, id_rs2_used_i, s2, l2);
    return id_valid_i && !flush_i && ((l1 && s1 < LOAD_LAT) || (l2 && s2 < LOAD_LAT));
  endfunction

  // Advance model state and DUT by one clock; leaves time at posedge + 1.
  task automatic tick();
    int unsigned s1, s2;
    bit l1, l2, st, adv;
    ins_t n;
    st  = model_stall();
    adv = id_valid_i && !st && !flush_i;
    search(id_rs1_i, id_rs1_used_i, s1, l1);
    search(id_rs2_i, id_rs2_used_i, s2, l2);
    if (rst_i) begin
      exp_sel1 = 0;
      exp_sel2 = 0;
      for (int unsigned i = 0; i < NS; i++) hist[i] = '{1'b0, 0, 1'b0, 1'b0};
    end else begin
      n = adv ? '{1'b1, int'(id_rd_i), id_regwrite_i, id_memread_i} : '{1'b0, 0, 1'b0, 1'b0};
      exp_sel1 = adv ? s1 : 0;
      exp_sel2 = adv ? s2 : 0;
      hist.push_front(n);
      void'(hist.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int unsigned rs1, input bit u1,
                       input int unsigned rs2, input bit u2,
                       input int unsigned rd, input bit rw, input bit ld);
    id_valid_i    = v;
    id_rs1_i      = AW'(rs1);
    id_rs1_used_i = u1;
    id_rs2_i      = AW'(rs2);
    id_rs2_used_i = u2;
    id_rd_i       = AW'(rd);
    id_regwrite_i = rw;
    id_memread_i  = ld;
    flush_i       = 1'b0;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(1, 3, 1, 2, 1, 3, 1, 1);
    tick();
    tick();
    rst_i = 1'b0;
    drive(1, 3, 1, 2, 1, 4, 1, 0);
    #1;
    checks++;
    if (fwd1_sel_o !== '0 || fwd2_sel_o !== '0) begin
      errors++;
      $display("FAIL reset_sel got %0d/%0d want 0/0", fwd1_sel_o, fwd2_sel_o);
    end
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got %0b want 0", stall_o);
    end
  endtask

  task automatic test_alu_fwd();
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    drive(1, 5, 1, 0, 0, 6, 1, 0);
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL alu_stall got %0b want 0", stall_o);
    end
    tick();
    checks++;
    if (fwd1_sel_o !== SELW'(1)) begin
      errors++;
      $display("FAIL alu_fwd1 got %0d want 1", fwd1_sel_o);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    drive(1, 0, 0, 7, 1, 8, 1, 0);
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall1 got %0b want 1", stall_o);
    end
    tick();
    checks++;
    if (stall_o !== 1'b0 || fwd2_sel_o !== '0) begin
      errors++;
      $display("FAIL lu_stall2 got stall=%0b sel=%0d want 0/0", stall_o, fwd2_sel_o);
    end
    tick();
    checks++;
    if (fwd2_sel_o !== SELW'(2)) begin
      errors++;
      $display("FAIL lu_fwd2 got %0d want 2", fwd2_sel_o);
    end
  endtask

  task automatic test_shadow();
    do_reset();
    drive(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    drive(1, 0, 0, 0, 0, 7, 1, 0);
    tick();
    drive(1, 7, 1, 0, 0, 9, 1, 0);
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL shadow_stall got %0b want 0", stall_o);
    end
    tick();
    checks++;
    if (fwd1_sel_o !== SELW'(1)) begin
      errors++;
      $display("FAIL shadow_fwd1 got %0d want 1", fwd1_sel_o);
    end
  endtask

  task automatic test_x0();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    tick();
    drive(1, 0, 1, 0, 1, 3, 1, 0);
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL x0_stall got %0b want 0", stall_o);
    end
    tick();
    checks++;
    if (fwd1_sel_o !== '0 || fwd2_sel_o !== '0) begin
      errors++;
      $display("FAIL x0_sel got %0d/%0d want 0/0", fwd1_sel_o, fwd2_sel_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    drive(1, 0, 0, 7, 1, 9, 1, 0);
    flush_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall got %0b want 0", stall_o);
    end
    tick();
    checks++;
    if (fwd1_sel_o !== '0 || fwd2_sel_o !== '0) begin
      errors++;
      $display("FAIL flush_sel got %0d/%0d want 0/0", fwd1_sel_o, fwd2_sel_o);
    end
    // Flushed x9 writer must not be in slot0; the load stays in slot1.
    drive(1, 9, 1, 7, 1, 10, 1, 0);
    tick();
    checks++;
    if (fwd1_sel_o !== '0 || fwd2_sel_o !== SELW'(2)) begin
      errors++;
      $display("FAIL flush_bubble got %0d/%0d want 0/2", fwd1_sel_o, fwd2_sel_o);
    end
  endtask

  task automatic test_wb_slot();
    do_reset();
    drive(1, 0, 0, 0, 0, 12, 1, 0);
    tick();
    idle();
    tick();
    tick();
    drive(1, 12, 1, 0, 0, 13, 1, 0);
    tick();
    checks++;
    if (fwd1_sel_o !== SELW'(WB_SEL)) begin
      errors++;
      $display("FAIL wb_slot got %0d want %0d", fwd1_sel_o, WB_SEL);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    drive(1, 0, 0, 7, 1, 8, 1, 0);
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL rms_pre got %0b want 1", stall_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++;
    if (stall_o !== 1'b0 || fwd2_sel_o !== '0) begin
      errors++;
      $display("FAIL rms_post got stall=%0b sel=%0d want 0/0", stall_o, fwd2_sel_o);
    end
  endtask

  task automatic test_random();
    bit st;
    do_reset();
    for (int unsigned c = 0; c < 400; c++) begin
      rst_i = ($urandom_range(49) == 0);
      drive($urandom_range(9) < 8, $urandom_range(3), $urandom_range(1) == 1,
            $urandom_range(3), $urandom_range(1) == 1, $urandom_range(3),
            $urandom_range(9) < 8, $urandom_range(9) < 4);
      flush_i = ($urandom_range(9) == 0);
      #1;
      st = model_stall();
      checks++;
      if (stall_o !== st) begin
        errors++;
        $display("FAIL rnd_stall cyc %0d got %0b want %0b", c, stall_o, st);
      end
      tick();
      checks++;
      if (fwd1_sel_o !== SELW'(exp_sel1) || fwd2_sel_o !== SELW'(exp_sel2)) begin
        errors++;
        $display("FAIL rnd_sel cyc %0d got %0d/%0d want %0d/%0d",
                 c, fwd1_sel_o, fwd2_sel_o, exp_sel1, exp_sel2);
      end
    end
    rst_i = 1'b0;
  endtask

  initial begin
    for (int unsigned i = 0; i < NS; i++) hist.push_back('{1'b0, 0, 1'b0, 1'b0});
    rst_i = 1'b0;
    idle();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_shadow();
    test_x0();
    test_flush();
    test_wb_slot();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
